// File: rtl/sync_bus_transceiver_pkg.sv
// rtl/sync_bus_transceiver_pkg.sv - state encodings and shared helpers for sync_bus_transceiver
package sync_bus_transceiver_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DRIVE   = 2'd1;
    localparam logic [1:0] ST_TURN    = 2'd2;
    localparam logic [1:0] ST_CAPTURE = 2'd3;

    // Destination chosen from the registered request pair, as seen from IDLE.
    function automatic logic [1:0] select_target(input logic cs_q, input logic dce_q);
        if (cs_q) begin
            return ST_IDLE;
        end
        return dce_q ? ST_CAPTURE : ST_DRIVE;
    endfunction

endpackage

// File: rtl/xcvr_turn_timer.sv
// rtl/xcvr_turn_timer.sv - loadable 4-bit down-counter timing the bus turnaround gap
module xcvr_turn_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       done
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != 4'd0) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == 4'd0);

endmodule

// File: rtl/sync_bus_transceiver.sv
// rtl/sync_bus_transceiver.sv - clocked bidirectional bus transceiver with hi-Z turnaround
// Optional odd-parity lane and sticky error flag: SYNC_BUS_TRANSCEIVER_PARITY_EN.
module sync_bus_transceiver #(
    parameter int WIDTH           = 8,
    parameter int INVERTED_OUTPUT = 0,
    parameter int TURNAROUND      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs_n,
    input  logic             dce,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    inout  wire  [WIDTH-1:0] d_bus,
`ifdef SYNC_BUS_TRANSCEIVER_PARITY_EN
    inout  wire              d_bus_par,
    output logic             par_err,
`endif
    output logic             d_out_stb,
    output logic             bus_oe,
    output logic             busy
);
    import sync_bus_transceiver_pkg::*;

    localparam logic [WIDTH-1:0] INV_MASK  = (INVERTED_OUTPUT != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam bit               HAS_TURN  = (TURNAROUND > 0);
    localparam logic [3:0]       TURN_LOAD = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;

    logic             cs_q;
    logic             dce_q;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] d_in_q;
    logic [WIDTH-1:0] d_out_q;
    logic [WIDTH-1:0] d_out_d;
    logic             timer_load;
    logic             turn_done;

    xcvr_turn_timer u_turn_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (TURN_LOAD),
        .done     (turn_done)
    );

    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = select_target(cs_q, dce_q);
            end
            ST_DRIVE: begin
                if (cs_q || dce_q) begin
                    if (HAS_TURN) begin
                        state_d    = ST_TURN;
                        timer_load = 1'b1;
                    end else begin
                        state_d = select_target(cs_q, dce_q);
                    end
                end
            end
            ST_TURN: begin
                // Only the timer ends TURN; request changes just pick the exit.
                if (turn_done) begin
                    state_d = select_target(cs_q, dce_q);
                end
            end
            ST_CAPTURE: begin
                if (cs_q) begin
                    state_d = ST_IDLE;
                end else if (!dce_q) begin
                    state_d = ST_DRIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        d_out_d = d_out_q;
        if (state_q == ST_CAPTURE) begin
            d_out_d = d_bus ^ INV_MASK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_q    <= 1'b1;
            dce_q   <= 1'b0;
            state_q <= ST_IDLE;
            d_in_q  <= '0;
            d_out_q <= '0;
        end else begin
            cs_q    <= cs_n;
            dce_q   <= dce;
            state_q <= state_d;
            d_in_q  <= d_in ^ INV_MASK;
            d_out_q <= d_out_d;
        end
    end

    // Output enable decodes straight from the state register so reset releases the bus at once.
    assign bus_oe    = (state_q == ST_DRIVE);
    assign busy      = (state_q == ST_TURN);
    assign d_out_stb = (state_q == ST_CAPTURE);
    assign d_out     = d_out_q;
    assign d_bus     = bus_oe ? d_in_q : {WIDTH{1'bz}};

`ifdef SYNC_BUS_TRANSCEIVER_PARITY_EN
    logic cs_qq;
    logic par_err_q;
    logic par_err_d;
    logic par_bad;

    assign d_bus_par = bus_oe ? ~(^d_in_q) : 1'bz;
    assign par_bad   = (state_q == ST_CAPTURE) && !(^{d_bus_par, d_bus});

    always_comb begin
        par_err_d = par_err_q;
        if (par_bad) begin
            par_err_d = 1'b1;
        end else if (cs_qq && !cs_q) begin
            par_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_qq     <= 1'b1;
            par_err_q <= 1'b0;
        end else begin
            cs_qq     <= cs_q;
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_sync_bus_transceiver.sv
// tb/tb_sync_bus_transceiver.sv - directed self-checking bench for sync_bus_transceiver
module tb_sync_bus_transceiver;

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    // A: true data, TURNAROUND=1
    logic       cs_n_a, dce_a, stb_a, oe_a, busy_a, drv_a;
    logic [3:0] din_a, dout_a, val_a;
    wire  [3:0] bus_a;
    assign bus_a = drv_a ? val_a : 4'bzzzz;

    // B: inverted data, TURNAROUND=1
    logic       cs_n_b, dce_b, stb_b, oe_b, busy_b, drv_b;
    logic [3:0] din_b, dout_b, val_b;
    wire  [3:0] bus_b;
    assign bus_b = drv_b ? val_b : 4'bzzzz;

    // C: true data, TURNAROUND=3
    logic       cs_n_c, dce_c, stb_c, oe_c, busy_c, drv_c;
    logic [3:0] din_c, dout_c, val_c;
    wire  [3:0] bus_c;
    assign bus_c = drv_c ? val_c : 4'bzzzz;

`ifdef SYNC_BUS_TRANSCEIVER_PARITY_EN
    logic par_val_a, perr_a, perr_b, perr_c;
    wire  par_a, par_b, par_c;
    assign par_a = drv_a ? par_val_a : 1'bz;
`endif

    sync_bus_transceiver #(.WIDTH(4), .INVERTED_OUTPUT(0), .TURNAROUND(1)) dut_a (
        .clk(clk), .rst(rst), .cs_n(cs_n_a), .dce(dce_a), .d_in(din_a), .d_out(dout_a),
        .d_bus(bus_a),
`ifdef SYNC_BUS_TRANSCEIVER_PARITY_EN
        .d_bus_par(par_a), .par_err(perr_a),
`endif
        .d_out_stb(stb_a), .bus_oe(oe_a), .busy(busy_a)
    );

    sync_bus_transceiver #(.WIDTH(4), .INVERTED_OUTPUT(1), .TURNAROUND(1)) dut_b (
        .clk(clk), .rst(rst), .cs_n(cs_n_b), .dce(dce_b), .d_in(din_b), .d_out(dout_b),
        .d_bus(bus_b),
`ifdef SYNC_BUS_TRANSCEIVER_PARITY_EN
        .d_bus_par(par_b), .par_err(perr_b),
`endif
        .d_out_stb(stb_b), .bus_oe(oe_b), .busy(busy_b)
    );

    sync_bus_transceiver #(.WIDTH(4), .INVERTED_OUTPUT(0), .TURNAROUND(3)) dut_c (
        .clk(clk), .rst(rst), .cs_n(cs_n_c), .dce(dce_c), .d_in(din_c), .d_out(dout_c),
        .d_bus(bus_c),
`ifdef SYNC_BUS_TRANSCEIVER_PARITY_EN
        .d_bus_par(par_c), .par_err(perr_c),
`endif
        .d_out_stb(stb_c), .bus_oe(oe_c), .busy(busy_c)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The bench and a DUT must never drive the same bus in the same cycle.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk1("no_contention", (oe_a & drv_a) | (oe_b & drv_b) | (oe_c & drv_c), 1'b0);
        end
    end

    initial begin
        rst    = 1'b1;
        cs_n_a = 1'b1; dce_a = 1'b0; din_a = 4'd0; drv_a = 1'b0; val_a = 4'd0;
        cs_n_b = 1'b1; dce_b = 1'b0; din_b = 4'd0; drv_b = 1'b0; val_b = 4'd0;
        cs_n_c = 1'b1; dce_c = 1'b0; din_c = 4'd0; drv_c = 1'b0; val_c = 4'd0;
`ifdef SYNC_BUS_TRANSCEIVER_PARITY_EN
        par_val_a = 1'b0;
`endif
        #2;
        chk1("rst_bus_oe", oe_a, 1'b0);
        chk4("rst_d_out", dout_a, 4'b0000);
        chk1("rst_stb", stb_a, 1'b0);
        chk1("rst_busy", busy_a, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // Drive 0101: bus_oe rises on the second edge, one TURN cycle on release.
        cs_n_a = 1'b0; dce_a = 1'b0; din_a = 4'b0101;
        tick();
        chk1("t1_oe_after_1clk", oe_a, 1'b0);
        tick();
        chk1("t1_oe_after_2clk", oe_a, 1'b1);
        chk4("t1_bus", bus_a, 4'b0101);
        cs_n_a = 1'b1;
        tick();
        chk1("t1_oe_hold", oe_a, 1'b1);
        tick();
        chk1("t1_turn_oe", oe_a, 1'b0);
        chk1("t1_turn_busy", busy_a, 1'b1);
        tick();
        chk1("t1_idle_busy", busy_a, 1'b0);
        chk1("t1_idle_oe", oe_a, 1'b0);

        // Capture 0100, then d_out holds after deselect.
        cs_n_a = 1'b0; dce_a = 1'b1; drv_a = 1'b1; val_a = 4'b0100;
        tick();
        tick();
        chk1("t2_stb", stb_a, 1'b1);
        chk1("t2_oe", oe_a, 1'b0);
        tick();
        chk4("t2_d_out", dout_a, 4'b0100);
        chk1("t2_stb_hold", stb_a, 1'b1);
        cs_n_a = 1'b1;
        tick();
        tick();
        val_a = 4'b1010;
        tick();
        chk4("t2_d_out_held", dout_a, 4'b0100);
        chk1("t2_stb_idle", stb_a, 1'b0);
        drv_a = 1'b0;

        // Async reset between edges in DRIVE.
        cs_n_a = 1'b0; dce_a = 1'b0; din_a = 4'b0110;
        tick();
        tick();
        chk1("t5_oe_before", oe_a, 1'b1);
        chk4("t5_bus_before", bus_a, 4'b0110);
        cs_n_a = 1'b1;
        #3 rst = 1'b1;
        #1;
        chk1("t5_oe_async", oe_a, 1'b0);
        chk4("t5_d_out_async", dout_a, 4'b0000);
        chk1("t5_stb_async", stb_a, 1'b0);
        tick();
        rst = 1'b0;

        // Inverted mode in both directions.
        cs_n_b = 1'b0; dce_b = 1'b0; din_b = 4'b0001;
        tick();
        tick();
        chk1("t3_oe", oe_b, 1'b1);
        chk4("t3_bus_inv", bus_b, 4'b1110);
        dce_b = 1'b1;
        tick();
        tick();
        chk1("t3_turn_busy", busy_b, 1'b1);
        drv_b = 1'b1; val_b = 4'b0011;
        tick();
        chk1("t3_capture_stb", stb_b, 1'b1);
        tick();
        chk4("t3_d_out_inv", dout_b, 4'b1100);
        cs_n_b = 1'b1;
        tick();
        tick();
        drv_b = 1'b0;

        // TURNAROUND=3: exactly three busy cycles, then CAPTURE; CAPTURE->DRIVE has no gap.
        cs_n_c = 1'b0; dce_c = 1'b0; din_c = 4'b1010;
        tick();
        tick();
        chk1("t4_oe", oe_c, 1'b1);
        dce_c = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("t4_turn_busy", busy_c, 1'b1);
            chk1("t4_turn_oe", oe_c, 1'b0);
            if (i == 0) begin
                drv_c = 1'b1; val_c = 4'b0111;
            end
        end
        tick();
        chk1("t4_after_busy", busy_c, 1'b0);
        chk1("t4_capture_stb", stb_c, 1'b1);
        tick();
        chk4("t4_d_out", dout_c, 4'b0111);
        drv_c = 1'b0; dce_c = 1'b0;
        tick();
        chk1("t4_cap_to_drive_busy1", busy_c, 1'b0);
        tick();
        chk1("t4_cap_to_drive_oe", oe_c, 1'b1);
        chk1("t4_cap_to_drive_busy2", busy_c, 1'b0);
        chk4("t4_cap_to_drive_bus", bus_c, 4'b1010);
        cs_n_c = 1'b1;
        tick();
        tick();
        tick();

`ifdef SYNC_BUS_TRANSCEIVER_PARITY_EN
        // 0001 with par=1 has even weight: sticky error, cleared by reselect.
        cs_n_a = 1'b0; dce_a = 1'b1; drv_a = 1'b1; val_a = 4'h1; par_val_a = 1'b1;
        tick();
        tick();
        tick();
        chk1("t6_par_err_set", perr_a, 1'b1);
        cs_n_a = 1'b1;
        tick();
        tick();
        tick();
        chk1("t6_par_err_sticky", perr_a, 1'b1);
        drv_a = 1'b0; cs_n_a = 1'b0; dce_a = 1'b0;
        tick();
        tick();
        chk1("t6_par_err_clear", perr_a, 1'b0);
        cs_n_a = 1'b1;
        tick();
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
